// File: rtl/avmm_rw_responder.sv
// Fixed-latency, byte-lane-writable 64-bit Avalon-MM slave RAM with a read-data
// pipeline, read/write access counters and a saturating out-of-range error counter.
module avmm_rw_responder #(
  parameter int unsigned ADDR_BITS    = 10,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [63:0] BASE_ADDR    = 64'h0
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [63:0] avs_address,
  input  logic [7:0]  avs_byteenable,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [63:0] avs_writedata,
  output logic [63:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [15:0] err_count
);

  localparam int unsigned DEPTH      = 2 ** ADDR_BITS;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned LANES      = 8;
  localparam int unsigned WORD_OFF_W = 61;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [WORD_OFF_W-1:0] word_off_c;
  logic [ADDR_BITS-1:0]  idx_c;
  logic                  in_range_c;
  logic [DATA_W-1:0]     rd_word_c;

  logic [DATA_W-1:0]       pipe_data_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_vld_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    rvalid_q;

  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;
  logic [15:0] err_count_q, err_count_d;
  logic [1:0]  err_inc_c;
  logic [16:0] err_sum_c;

  // Address decode: a 64-bit subtraction underflow is caught by the >= test.
  always_comb begin
    word_off_c = WORD_OFF_W'((avs_address - BASE_ADDR) >> 3);
    idx_c      = word_off_c[ADDR_BITS-1:0];
    in_range_c = (avs_address >= BASE_ADDR) && ((word_off_c >> ADDR_BITS) == '0);
    rd_word_c  = in_range_c ? mem[idx_c] : '0;
  end

  // Storage is intentionally not reset; lanes are written independently.
  always_ff @(posedge clock) begin
    if (avs_write && in_range_c) begin
      for (int i = 0; i < LANES; i++) begin
        if (avs_byteenable[i]) mem[idx_c][8*i +: 8] <= avs_writedata[8*i +: 8];
      end
    end
  end

  // Read pipeline: stage 0 captures pre-write contents; output loads READ_LATENCY edges later.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe_data_q[i] <= '0;
      pipe_vld_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      pipe_data_q[0] <= rd_word_c;
      pipe_vld_q[0]  <= avs_read;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_data_q[i] <= pipe_data_q[i-1];
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
      end
      rvalid_q <= pipe_vld_q[READ_LATENCY-1];
      if (pipe_vld_q[READ_LATENCY-1]) rdata_q <= pipe_data_q[READ_LATENCY-1];
    end
  end

  // Counter next-state; the error counter can take +2 in one cycle and saturates.
  always_comb begin
    rd_count_d  = rd_count_q + 32'(avs_read);
    wr_count_d  = wr_count_q + 32'(avs_write);
    err_inc_c   = 2'(avs_read && !in_range_c) + 2'(avs_write && !in_range_c);
    err_sum_c   = 17'(err_count_q) + 17'(err_inc_c);
    err_count_d = err_sum_c[16] ? 16'hFFFF : err_sum_c[15:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign rd_count          = rd_count_q;
  assign wr_count          = wr_count_q;
  assign err_count         = err_count_q;

endmodule

// File: doc/avmm_rw_responder.md
# avmm_rw_responder

Avalon-MM slave memory that answers the 64-bit `avmm_*_rw` master port of our HLS components (address, byteenable, read, readdata, write, writedata; no waitrequest, no readdatavalid). The master expects read data a fixed number of cycles after `read`, so this block is a fixed-latency, byte-lane-writable RAM with a read-data pipeline, access counters and an out-of-range error counter. It sits in component testbenches and in small standalone systems as the local memory behind a component's `avmm_0_rw` port.

## Interface
- `ADDR_BITS`, default 10: word-index width; depth is 2^ADDR_BITS 64-bit words.
- `READ_LATENCY`, default 2: cycles from `read` to valid `readdata`; legal range is 1..8.
- `BASE_ADDR`, default 64'h0: byte address of word 0; must be 8-byte aligned.

Ports (name, direction, width, meaning):
- `clock` in 1: the single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `avs_address` in 64: byte address from the master.
- `avs_byteenable` in 8: per-lane enable; bit i covers data[8i+7:8i].
- `avs_read` in 1: read request, one word per asserted cycle.
- `avs_write` in 1: write request.
- `avs_writedata` in 64: write data.
- `avs_readdata` out 64: read data, valid `READ_LATENCY` cycles after the request.
- `avs_readdatavalid` out 1: qualifies `avs_readdata`. It is a monitor aid; the master does not consume it.
- `rd_count` out 32: number of accepted reads, wraps modulo 2^32.
- `wr_count` out 32: number of accepted writes, wraps modulo 2^32.
- `err_count` out 16: number of out-of-range accesses, saturates at 16'hFFFF.

## Operation
- **Word index.** idx = (avs_address − BASE_ADDR) >> 3. Address bits [2:0] are ignored.
- **Range.** An access is in range when avs_address ≥ BASE_ADDR and idx < 2^ADDR_BITS. The subtraction is 64-bit; an underflow counts as out of range.
- **Write, in range.** For each lane i with byteenable[i]=1, mem[idx] lane i takes writedata lane i. Other lanes are unchanged. `byteenable`=0 changes nothing but is still counted.
- **Read, in range.** The block returns all 64 bits of mem[idx]. `byteenable` is ignored for reads.
- **Out of range.** A write is dropped. A read returns 64'h0 with `avs_readdatavalid`=1. Either case increments `err_count`.
- **Counters.** `rd_count` and `wr_count` increment on every asserted `avs_read` and `avs_write`, in range or not.
- **Read and write in the same cycle.**
  - Both are performed.
  - The read returns the pre-write contents (read-before-write).
  - `rd_count` and `wr_count` both increment.
  - `err_count` increments by 1 per out-of-range request, so +2 if both are out of range.
- **Back-to-back reads.** One read per cycle is fully pipelined, and results leave in issue order.
- **Memory contents.** Memory is not reset; its contents are undefined until written.
- **Output hold.** Between valid results, `avs_readdata` holds the last returned value.

## Timing
- **Reset values.** `avs_readdata`=0, `avs_readdatavalid`=0, `rd_count`=0, `wr_count`=0, `err_count`=0. All read-pipeline valid bits are cleared.
- **Reset mid-operation.** Asserting `resetn`=0 discards every in-flight read. No `avs_readdatavalid` pulse appears for those reads after reset is released.
- **Read latency.** A read sampled at edge t drives data and `avs_readdatavalid`=1 from edge t+READ_LATENCY, for one cycle.
- **Write timing.** A write sampled at edge t updates memory at edge t. A read sampled at t+1 or later returns the new data.
- **Counter timing.** Each counter updates at the edge that samples the request.
- **Throughput.** There is no stall path and no backpressure: one read and/or one write per cycle, sustained indefinitely.

## Test plan
1. **Full write then read.** Write 64'h0123_4567_89AB_CDEF to BASE_ADDR+0x18 with byteenable 8'hFF. Read the same address next cycle. Required: readdata = 64'h0123_4567_89AB_CDEF exactly READ_LATENCY cycles later; `wr_count`=1, `rd_count`=1.
2. **Byte lanes.** Preload word 0 with 64'h0. Write 64'hFFFF_FFFF_FFFF_FFFF with byteenable 8'b0101_0001. Read word 0. Required: 64'h00FF_00FF_0000_00FF.
3. **Pipelined stream.** Issue reads of words 0..7 on consecutive cycles, with word k holding k. Required: `avs_readdatavalid` high for 8 consecutive cycles starting at issue+READ_LATENCY, with data 0..7 in order.
4. **Same-cycle read and write.** Word 5 holds 64'hAA. In one cycle, read word 5 and write 64'hBB to word 5. Required: the read returns 64'hAA; a read issued the next cycle returns 64'hBB.
5. **Out of range.** Read and write address BASE_ADDR + 8·2^ADDR_BITS, then address BASE_ADDR−8 (with BASE_ADDR≠0). Required: reads return 0 with valid asserted, memory is unchanged, `err_count`=4.
6. **Reset mid-read.** Issue a read, then assert `resetn`=0 one cycle later (READ_LATENCY≥2). Required: no valid pulse after release, and all counters read 0.
